event_window_meter: RTL and testbench
=====================================

Name: event_window_meter

Overview:
- Downstream consumer of the periodic terminal-count flag produced by the flag counter (CounterwFlag_P).
- Uses each rising edge of that flag as a measurement-window boundary and counts rising edges of an external event line inside each window.
- At every boundary it latches the window count, pulses a valid strobe and restarts counting, so that {flag counter + this block} form a frequency/event-rate meter.
- Replaces the ad-hoc One_Shot + CounterEvents pairing with a single aligned, synchronized block.

Parameters:
- NBITS, 6, width of the event counter and result register.
- SYNC_STAGES, 2, flip-flop stages synchronizing event_in (legal range 2..4).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  measurement enable; low forces IDLE.
- flag_in  input  1  window-boundary flag from the flag counter; level, may stay high more than one cycle.
- event_in  input  1  event line, asynchronous to clk.
- live_count  output  NBITS  running count of the current window.
- result  output  NBITS  count of the last completed window.
- result_valid  output  1  one-cycle strobe: result updated.
- overflow  output  1  last completed window saturated.
- busy  output  1  high in MEASURE state.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - Synchronizer and flag/edge history registers 0.
  - State IDLE.
- Event path:
  - event_in passes through SYNC_STAGES flops, then a history flop.
  - ev_edge = sync_out & ~history.
  - A low-to-high transition on event_in reaches live_count in SYNC_STAGES+1 clk edges (3 at default).
- Flag path:
  - flag_q registers flag_in.
  - fl_edge = flag_in & ~flag_q, combinational in the cycle flag_in first reads 1.
  - A flag held high for k cycles produces exactly one fl_edge.
- State machine:
  - IDLE:
    - live_count held 0; result and overflow hold their last value; busy=0.
    - enable=1 -> ARMED.
  - ARMED:
    - Waits to align with a window start. Events are ignored; live_count stays 0.
    - fl_edge -> MEASURE with live_count=0. No result_valid is produced (the partial first window is discarded).
    - enable=0 -> IDLE.
  - MEASURE (busy=1):
    - Each ev_edge increments live_count, saturating at 2^NBITS-1. The saturated condition is held in an internal sat bit.
    - On fl_edge:
      - result <= live_count + ev_edge, saturated.
      - overflow <= sat OR the add saturates.
      - live_count <= 0 and sat <= 0.
      - result_valid=1 for exactly the next cycle.
    - An event edge coincident with fl_edge belongs to the closing window.
    - enable=0 -> IDLE: live_count cleared, no result_valid, result/overflow held.
- Boundary conditions:
  - Window with no events: result=0, result_valid still pulses.
  - Back-to-back fl_edges are only possible with gaps of at least 2 cycles, because flag_in must return low for one cycle. Each fl_edge yields its own result.
  - Reset asserted mid-window aborts immediately to IDLE with all outputs 0. After reset release the block needs enable and re-arming.
  - enable and fl_edge rising in the same cycle while in IDLE: the transition to ARMED happens; that fl_edge is not consumed.
- Width rules:
  - All arithmetic is unsigned NBITS.
  - live_count never wraps.
  - overflow is valid in the same cycle as result_valid and is held until the next result.

Test Plan:
- Reset release, enable=1, flag_in pulses every 16 clk, event_in toggling with period 4 clk.
  - First window discarded (no result_valid).
  - Each subsequent result_valid carries result=4, overflow=0.
- event_in stuck low, two windows -> result=0, result_valid pulses once per flag, overflow=0.
- NBITS=6, event period 2 clk, window 256 clk -> live_count stops at 63, result=63, overflow=1. The next 16-clk window with 4 events gives result=4, overflow=0.
- flag_in held high for 5 cycles per boundary -> exactly one result_valid per boundary. An event edge landing in the same cycle as fl_edge is counted in the closing window (e.g. result=5, not 4).
- enable dropped mid-window with live_count=3:
  - Next cycle live_count=0, busy=0, no result_valid, previous result unchanged.
  - After re-enable the first window is again discarded.
- reset asserted asynchronously between clock edges with live_count=7 and result=4 -> all outputs 0 before the next clk edge, state IDLE.

Source files
------------

// File: rtl/event_window_meter.sv
// Event-rate meter: counts synchronized rising edges of event_in between
// successive rising edges of flag_in and reports each completed window.
module event_window_meter #(
  parameter int unsigned NBITS       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flag_in,
  input  logic             event_in,
  output logic [NBITS-1:0] live_count,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [NBITS-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   flag_q;
  logic [NBITS-1:0]       live_q, live_d;
  logic [NBITS-1:0]       result_q, result_d;
  logic                   sat_q, sat_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic                   ev_edge;
  logic                   fl_edge;
  logic                   at_max;
  logic [NBITS-1:0]       close_cnt;
  logic                   close_ovf;

  assign ev_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fl_edge = flag_in & ~flag_q;
  assign at_max  = (live_q == CNT_MAX);

  // An event edge arriving with the boundary is folded into the closing window.
  assign close_cnt = at_max ? CNT_MAX : live_q + NBITS'(ev_edge);
  assign close_ovf = sat_q | (at_max & ev_edge);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      flag_q   <= 1'b0;
      live_q   <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], event_in};
      hist_q   <= sync_q[SYNC_STAGES-1];
      flag_q   <= flag_in;
      live_q   <= live_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    result_d = result_q;
    sat_d    = sat_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        live_d = '0;
        sat_d  = 1'b0;
        if (enable) state_d = ARMED;
      end
      ARMED: begin
        live_d = '0;
        sat_d  = 1'b0;
        if (!enable)      state_d = IDLE;
        else if (fl_edge) state_d = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
          live_d  = '0;
          sat_d   = 1'b0;
        end else if (fl_edge) begin
          result_d = close_cnt;
          ovf_d    = close_ovf;
          live_d   = '0;
          sat_d    = 1'b0;
          valid_d  = 1'b1;
        end else if (ev_edge) begin
          if (at_max) sat_d  = 1'b1;
          else        live_d = live_q + NBITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        live_d  = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  assign live_count   = live_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_event_window_meter.sv
// Randomized scoreboard bench for event_window_meter against a window-level
// behavioural model built from input sample histories.
module tb_event_window_meter;

  localparam int unsigned NBITS = 6;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned CMAX  = (1 << NBITS) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             flag_in = 1'b0;
  logic             event_in = 1'b0;
  logic [NBITS-1:0] live_count;
  logic [NBITS-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic             busy;

  event_window_meter #(
    .NBITS      (NBITS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .flag_in     (flag_in),
    .event_in    (event_in),
    .live_count  (live_count),
    .result      (result),
    .result_valid(result_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ARMED, M_MEAS} mmode_t;
  typedef struct { int unsigned res; bit ovf; } exp_t;

  exp_t        exp_q[$];
  mmode_t      m_mode   = M_IDLE;
  int unsigned m_total  = 0;   // true number of events in open window, unbounded
  int unsigned m_result = 0;
  bit          m_ovf    = 1'b0;
  bit          f_prev   = 1'b0;
  bit          evh[$]   = '{0, 0, 0};  // event_in samples of the last SYNC+1 edges

  always @(posedge clk or negedge reset) begin
    bit ev, fl;
    int unsigned t;
    if (!reset) begin
      m_mode = M_IDLE; m_total = 0; m_result = 0; m_ovf = 1'b0;
      f_prev = 1'b0; evh = '{0, 0, 0}; exp_q.delete();
    end else begin
      // A rise sampled SYNC edges ago is counted at this edge.
      ev = evh[1] & ~evh[0];
      fl = flag_in & ~f_prev;
      f_prev = flag_in;
      evh.push_back(event_in);
      void'(evh.pop_front());
      case (m_mode)
        M_IDLE:  if (enable) m_mode = M_ARMED;
        M_ARMED: begin
          if (!enable) m_mode = M_IDLE;
          else if (fl) begin m_mode = M_MEAS; m_total = 0; end
        end
        default: begin
          if (!enable) begin
            m_mode = M_IDLE; m_total = 0;
          end else if (fl) begin
            t = m_total + ev;
            m_result = (t > CMAX) ? CMAX : t;
            m_ovf = (t > CMAX);
            exp_q.push_back('{m_result, m_ovf});
            m_total = 0;
          end else begin
            m_total += ev;
          end
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    int unsigned exp_live;
    if (!reset) begin
      chk(live_count == 0 && result == 0 && !result_valid && !overflow && !busy,
          "reset_outputs", {live_count, result, result_valid, overflow, busy}, 0);
    end else begin
      exp_live = (m_total > CMAX) ? CMAX : m_total;
      chk(live_count == exp_live, "live_count", live_count, exp_live);
      chk(busy == (m_mode == M_MEAS), "busy", busy, m_mode == M_MEAS);
      if (result_valid) begin
        chk(exp_q.size() != 0, "unexpected_valid", 1, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(result == e.res, "result", result, e.res);
          chk(overflow == e.ovf, "overflow", overflow, e.ovf);
        end
      end
      chk(exp_q.size() == 0, "missed_valid", 0, 1);
      chk(result == m_result, "result_hold", result, m_result);
      chk(overflow == m_ovf, "overflow_hold", overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit f, input bit e, input bit en);
    @(negedge clk);
    flag_in = f; event_in = e; enable = en;
  endtask

  task automatic run(input int n, input int fper, input int flen, input int ehalf, input bit en);
    for (int i = 0; i < n; i++)
      drive((i % fper) < flen, (ehalf == 0) ? 1'b0 : 1'(((i / ehalf) % 2)), en);
  endtask

  initial begin
    bit ev_lvl, en_lvl;
    int unsigned len, flen;

    repeat (4) drive(0, 0, 0);
    @(negedge clk); #3 reset = 1'b1;

    run(100, 16, 1, 2, 1);   // 4 events per 16-cycle window
    run(48, 16, 1, 0, 1);    // empty windows
    run(300, 256, 1, 1, 1);  // long window saturates
    run(48, 16, 1, 2, 1);
    run(64, 16, 5, 2, 1);    // wide flag pulses

    // enable dropped mid-window, then re-armed
    run(32, 16, 1, 2, 1);
    run(8, 16, 1, 2, 1);
    repeat (3) drive(0, 0, 0);
    run(64, 16, 1, 2, 1);

    // asynchronous reset while a window is open
    run(32, 16, 1, 2, 1);
    for (int i = 0; i < 40 && live_count < 7; i++) drive(0, 1'(i % 2), 1);
    #2 reset = 1'b0;
    #1;
    chk(live_count == 0, "async_rst_live", live_count, 0);
    chk(result == 0, "async_rst_result", result, 0);
    chk(!result_valid && !overflow && !busy, "async_rst_flags",
        {result_valid, overflow, busy}, 0);
    repeat (3) drive(0, 0, 1);
    @(negedge clk); #3 reset = 1'b1;
    run(64, 16, 1, 2, 1);

    // randomized windows with random flag widths, events and enable drops
    ev_lvl = 1'b0; en_lvl = 1'b1;
    for (int w = 0; w < 60; w++) begin
      len  = $urandom_range(40, 4);
      flen = $urandom_range((len > 6) ? 5 : len - 1, 1);
      for (int i = 0; i < int'(len); i++) begin
        if ($urandom_range(2, 0) == 0) ev_lvl = ~ev_lvl;
        if (en_lvl && $urandom_range(80, 0) == 0) en_lvl = 1'b0;
        else if (!en_lvl && $urandom_range(3, 0) == 0) en_lvl = 1'b1;
        drive(i < int'(flen), ev_lvl, en_lvl);
      end
    end
    repeat (4) drive(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
